uart_rx: RTL

//  Receiver for the uart_tx framing: start bit 0, 8 data bits MSB first, stop bit 1.

---
 rtl/uart_rx.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// UART receiver: start bit 0, 8 data bits MSB first, stop bit 1, with framing-error
// and overrun flags and a valid/ready byte output that never stalls the receiver.
module uart_rx #(
    parameter int CLKS_PER_BIT = 1,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int HALF  = (CLKS_PER_BIT - 1) / 2;
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BIT_LOAD   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] START_LOAD = (HALF == 0) ? BIT_LOAD : CNT_W'(HALF - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             w_rx_s;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_idx;
    logic [7:0]       r_shreg;
    logic [7:0]       r_data;
    logic             r_valid;
    logic             r_frame_err;
    logic             r_overrun;
    logic             w_sample;
    logic             w_done;
    logic             w_stop_bad;

    // Synchronizer flops reset to 1 so a reset never looks like a start bit
    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign w_rx_s = rx;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] r_sync;
            always_ff @(posedge CLK or negedge RESETN) begin
                if (!RESETN) begin
                    r_sync <= '1;
                end else begin
                    r_sync[0] <= rx;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        r_sync[i] <= r_sync[i-1];
                    end
                end
            end
            assign w_rx_s = r_sync[SYNC_STAGES-1];
        end
    endgenerate

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (!w_rx_s) begin
                    w_next = (HALF == 0) ? S_DATA : S_START;
                end
            end
            S_START: begin
                if (w_sample) begin
                    w_next = w_rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (w_sample && (r_idx == 3'd0)) begin
                    w_next = S_STOP;
                end
            end
            S_STOP: begin
                if (w_sample) begin
                    w_next = w_rx_s ? S_IDLE : S_WAIT_HIGH;
                end
            end
            S_WAIT_HIGH: begin
                if (w_rx_s) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_sample   = (r_cnt == '0);
        w_done     = (r_state == S_STOP) && w_sample && w_rx_s;
        w_stop_bad = (r_state == S_STOP) && w_sample && !w_rx_s;
        busy       = (r_state != S_IDLE);
    end

    // Bit timing: cnt counts down to the next sample point, idx walks MSB to LSB
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_cnt   <= '0;
            r_idx   <= 3'd0;
            r_shreg <= 8'h00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_rx_s) begin
                        r_cnt <= START_LOAD;
                        r_idx <= 3'd7;
                    end
                end
                S_START: begin
                    if (!w_sample) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (!w_rx_s) begin
                        r_cnt <= BIT_LOAD;
                        r_idx <= 3'd7;
                    end
                end
                S_DATA: begin
                    if (!w_sample) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_shreg[r_idx] <= w_rx_s;
                        r_cnt          <= BIT_LOAD;
                        r_idx          <= r_idx - 1'b1;
                    end
                end
                S_STOP: begin
                    if (!w_sample) begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // A pending unaccepted byte wins; a new byte arriving on top of it is dropped
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_data      <= 8'h00;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_stop_bad;
            r_overrun   <= w_done && r_valid && !ready;
            if (w_done && (!r_valid || ready)) begin
                r_data  <= r_shreg;
                r_valid <= 1'b1;
            end else if (r_valid && ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign data      = r_data;
    assign valid     = r_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule
